// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and default widths for the VGA/CPU memory arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int STREAK_W   = 4;

endpackage

// File: rtl/arb_priority.sv
// rtl/arb_priority.sv - single-winner priority pick between CPU and VGA
module arb_priority (
    input  logic cpu_elig,
    input  logic vga_elig,
    input  logic vga_blank,
    input  logic streak_max,
    output logic grant_cpu,
    output logic grant_vga
);

    // VGA wins contention during active video unless it has starved the CPU
    always_comb begin
        grant_cpu = cpu_elig & (~vga_elig | vga_blank | streak_max);
        grant_vga = vga_elig & ~grant_cpu;
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - shares one synchronous RAM port between CPU MEM stage and VGA fetch
module vga_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int MAX_VGA_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic              vga_blank,
    output logic              vga_gnt,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VGA_STREAK);

    owner_t              rd_owner;
    logic [STREAK_W-1:0] streak;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   cpu_rdata_q;
    logic [DATA_W-1:0]   vga_rdata_q;

    logic cpu_elig;
    logic vga_elig;
    logic grant_cpu;
    logic grant_vga;
    owner_t owner_next;
    logic [STREAK_W-1:0] streak_next;

    // Requests are masked while reset is held so every output reads 0 during reset;
    // the CPU may not re-issue during its own load response cycle
    always_comb begin
        cpu_elig = reset & cpu_req & (rd_owner != OWN_CPU);
        vga_elig = reset & vga_req;
    end

    arb_priority u_priority (
        .cpu_elig   (cpu_elig),
        .vga_elig   (vga_elig),
        .vga_blank  (vga_blank),
        .streak_max (streak == STREAK_MAX),
        .grant_cpu  (grant_cpu),
        .grant_vga  (grant_vga)
    );

    // Winner drives the RAM port; idle cycles hold the last address and data
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        if (grant_cpu) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else if (grant_vga) begin
            mem_addr  = vga_addr;
        end
    end

    // Response routing and pipeline stall, driven from the owner of last cycle's read
    always_comb begin
        cpu_rvalid = (rd_owner == OWN_CPU);
        vga_rvalid = (rd_owner == OWN_VGA);
        cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
        vga_rdata  = vga_rvalid ? mem_rdata : vga_rdata_q;
        vga_gnt    = grant_vga;
        cpu_stall  = reset & cpu_req & ~((grant_cpu & cpu_we) | cpu_rvalid);
    end

    // Next read owner and starvation streak
    always_comb begin
        owner_next = OWN_NONE;
        if (grant_cpu && !cpu_we) begin
            owner_next = OWN_CPU;
        end else if (grant_vga) begin
            owner_next = OWN_VGA;
        end

        streak_next = streak;
        if (!cpu_req || grant_cpu) begin
            streak_next = '0;
        end else if (grant_vga && cpu_elig && (streak != STREAK_MAX)) begin
            streak_next = streak + 1'b1;
        end
    end

    // State registers; reset drops any outstanding response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner    <= OWN_NONE;
            streak      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            rd_owner    <= owner_next;
            streak      <= streak_next;
            addr_q      <= mem_addr;
            wdata_q     <= mem_wdata;
            cpu_rdata_q <= cpu_rdata;
            vga_rdata_q <= vga_rdata;
        end
    end

endmodule
